// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Decoupled instruction-fetch front end. Holds the fetch PC, issues one
//   request per cycle to a synchronous instruction memory with a fixed
//   1-cycle read latency, buffers returned words together with their PC in a
//   DEPTH-entry FIFO, and hands them to decode over a valid/ready handshake.
//   A redirect flushes every buffered and in-flight fetch and restarts
//   fetching at the new (word-aligned) PC.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   imem_req     fetch request this cycle
//   imem_addr    fetch address (current fetch PC)
//   imem_rdata   instruction word, valid the cycle after an accepted request
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch PC, bits [1:0] ignored
//   out_valid    FIFO head valid
//   out_ready    decode accepts the head entry
//   out_instr    head instruction (0 when empty)
//   out_pc       PC of head instruction (0 when empty)
//   fifo_count   occupied FIFO entries
module fetch_queue_unit #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [DATA_W-1:0]        imem_rdata,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_instr,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
    logic              inflight_q,    inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;
    logic [CNT_W-1:0]  count_q,       count_d;

    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

    logic [CNT_W:0]    occupancy;
    logic              credit_ok;
    logic              not_empty;
    logic              push;
    logic              pop;
    logic              unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Entries already buffered plus the one that may still be returning must
    // leave room; a pop in the same cycle is deliberately not credited so the
    // issue decision never depends on out_ready.
    assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    assign credit_ok = occupancy < (CNT_W+1)'(DEPTH);

    // Qualified with rst_n so no request is seen while reset is held.
    assign imem_req  = rst_n && !redirect && credit_ok;
    assign imem_addr = fetch_pc_q;

    assign not_empty  = (count_q != '0);
    assign out_valid  = not_empty && !redirect;
    assign out_instr  = not_empty ? instr_mem_q[rd_ptr_q] : '0;
    assign out_pc     = not_empty ? pc_mem_q[rd_ptr_q]    : '0;
    assign fifo_count = count_q;

    // A response returning in a redirect cycle belongs to the old stream.
    assign push = inflight_q && !redirect;
    assign pop  = out_valid && out_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            inflight_d = imem_req;
            if (imem_req) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_STEP);
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage is never read while count is 0, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

    localparam logic [31:0] TAG = 32'hA5A50000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, RESET_PC = 0
    logic        rst_n, imem_req, redirect, out_valid, out_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc;
    logic [2:0]  fifo_count;

    // Second instance for PC wrap-around, RESET_PC = 0xFFFFFFF8
    logic        rst_n_w, imem_req_w, redirect_w, out_valid_w, out_ready_w;
    logic [31:0] imem_addr_w, imem_rdata_w, redirect_pc_w, out_instr_w, out_pc_w;
    logic [2:0]  fifo_count_w;

    fetch_queue_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fifo_count(fifo_count)
    );

    fetch_queue_unit #(.RESET_PC(32'hFFFFFFF8)) dut_w (
        .clk(clk), .rst_n(rst_n_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_instr(out_instr_w),
        .out_pc(out_pc_w), .fifo_count(fifo_count_w)
    );

    // Synchronous memories with 1-cycle latency; a poison word is returned when
    // no request was made so that a spurious push shows up as a bad instruction.
    always @(posedge clk) imem_rdata   <= imem_req   ? (imem_addr   ^ TAG) : 32'hDEADBEEF;
    always @(posedge clk) imem_rdata_w <= imem_req_w ? (imem_addr_w ^ TAG) : 32'hDEADBEEF;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] wtab [4];
    logic [31:0] exp_pc;
    int          pops;
    logic        overflow;

    initial begin
        wtab = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
        rst_n = 1'b0; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        rst_n_w = 1'b0; out_ready_w = 1'b1; redirect_w = 1'b0; redirect_pc_w = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_req",   imem_req,   0);
        check_val("rst_valid", out_valid,  0);
        check_val("rst_count", fifo_count, 0);
        check_val("rst_pc",    out_pc,     0);
        check_val("rst_instr", out_instr,  0);

        // ---------------- streaming, out_ready=1 ----------------
        rst_n = 1'b1;
        #1;
        check_val("s_addr0", imem_addr, 0);
        check_val("s_req0",  imem_req,  1);
        for (int c = 1; c < 8; c++) begin
            next_cycle();
            check_val("s_addr", imem_addr, 32'(4 * c));
            check_val("s_req",  imem_req,  1);
            check_val("s_cnt_le1", 32'(fifo_count <= 3'd1), 1);
            if (c >= 2) begin
                check_val("s_valid", out_valid, 1);
                check_val("s_pc",    out_pc,    32'(4 * (c - 2)));
                check_val("s_instr", out_instr, 32'(4 * (c - 2)) ^ TAG);
            end else begin
                check_val("s_valid1", out_valid, 0);
            end
        end

        // ---------------- fill to full, then drain ----------------
        rst_n = 1'b0; out_ready = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        repeat (10) next_cycle();
        check_val("f_count", fifo_count, 4);
        check_val("f_req",   imem_req,   0);
        check_val("f_addr",  imem_addr,  32'h10);
        check_val("f_valid", out_valid,  1);
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_val("d_pc",    out_pc,    32'(4 * k));
            check_val("d_instr", out_instr, 32'(4 * k) ^ TAG);
            if (k == 0) check_val("d_req_full", imem_req, 0);
            if (k == 1) begin
                check_val("d_req_resume",  imem_req,  1);
                check_val("d_addr_resume", imem_addr, 32'h10);
            end
            next_cycle();
        end

        // ---------------- redirect with 3 buffered, 1 in flight ----------------
        rst_n = 1'b0; out_ready = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        repeat (4) next_cycle();
        check_val("r_count_pre", fifo_count, 3);
        redirect = 1'b1; redirect_pc = 32'h00000103;
        #1;
        check_val("r_valid_cyc", out_valid, 0);
        check_val("r_req_cyc",   imem_req,  0);
        next_cycle();
        redirect = 1'b0; out_ready = 1'b1;
        #1;
        check_val("r_valid_after", out_valid,  0);
        check_val("r_count_after", fifo_count, 0);
        check_val("r_addr",        imem_addr,  32'h100);
        check_val("r_req",         imem_req,   1);
        next_cycle();
        check_val("r_no_stale", out_valid, 0);
        next_cycle();
        check_val("r_valid_new", out_valid, 1);
        check_val("r_pc_new",    out_pc,    32'h100);
        check_val("r_instr_new", out_instr, 32'hA5A50100);
        next_cycle();
        check_val("r_pc_next",   out_pc,    32'h104);

        // ---------------- PC wrap-around ----------------
        rst_n_w = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) check_val("w_addr", imem_addr_w, wtab[i]);
            if (i >= 2) begin
                check_val("w_valid", out_valid_w, 1);
                check_val("w_pc",    out_pc_w,    wtab[i-2]);
                check_val("w_instr", out_instr_w, wtab[i-2] ^ TAG);
            end
            next_cycle();
        end

        // ---------------- async reset while full ----------------
        out_ready = 1'b0;
        repeat (8) next_cycle();
        check_val("a_count_full", fifo_count, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("a_valid", out_valid,  0);
        check_val("a_count", fifo_count, 0);
        check_val("a_pc",    out_pc,     0);
        check_val("a_instr", out_instr,  0);
        check_val("a_req",   imem_req,   0);
        next_cycle();
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        check_val("a_restart_addr", imem_addr, 0);
        check_val("a_restart_req",  imem_req,  1);
        next_cycle();
        next_cycle();
        check_val("a_first_pc", out_pc, 0);

        // ---------------- random ready and redirects vs scoreboard ----------------
        exp_pc = '0; pops = 0; overflow = 1'b0;
        for (int it = 0; it < 800; it++) begin
            @(posedge clk);
            #1;
            out_ready   = ($urandom_range(0, 1) == 1);
            redirect    = (it == 0) || ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            #1;
            if (fifo_count > 3'd4) overflow = 1'b1;
            if (redirect) begin
                check_val("rnd_redir_valid", out_valid, 0);
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (out_valid && out_ready) begin
                check_val("rnd_pc",    out_pc,    exp_pc);
                check_val("rnd_instr", out_instr, exp_pc ^ TAG);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
        redirect = 1'b0;
        check_val("rnd_overflow", overflow, 0);
        check_val("rnd_progress", 32'(pops > 100), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
